posit8_1_encoder: RTL and testbench
===================================

POSIT8_1_ENCODER -- requirements
Module: posit8_1_encoder

Interface
REQ-001 SHALL have no parameters; the format is fixed at posit<8,1>: 8-bit word, es=1, 4-bit fraction field on input.
REQ-002 SHALL use one clock and a synchronous, active-high reset.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  input fields valid.
REQ-006 in_ready  out  1  encoder can accept input this cycle.
REQ-007 in_sign  in  1  sign of the value.
REQ-008 in_regi  in  4  regime k, two's complement; legal range -6..+6.
REQ-009 in_expo  in  1  exponent bit.
REQ-010 in_frac  in  4  fraction magnitude bits, MSB first.
REQ-011 in_zero  in  1  value is zero.
REQ-012 in_nar  in  1  value is NaR.
REQ-013 out_valid  out  1  out_posit/out_sat valid.
REQ-014 out_ready  in  1  downstream accepts output.
REQ-015 out_posit  out  8  encoded posit word.
REQ-016 out_sat  out  1  regime input was out of range and the result was saturated.

Function
REQ-017 SHALL be a 3-stage pipeline: S1 regime/body build, S2 round/saturate, S3 sign negation and output register; latency is exactly 3 cycles from input handshake to out_valid when not stalled.
REQ-018 SHALL accept input when in_valid & in_ready; in_ready = ~out_valid | out_ready, combinational.
REQ-019 SHALL stall all stages together when out_valid & ~out_ready; out_posit/out_sat held stable while stalled.
REQ-020 SHALL complete the output transfer on out_valid & out_ready; bubbles propagate as invalid stages; no collapse required.
REQ-021 S1 SHALL form a left-justified 12-bit body: for k>=0, (k+1) ones then 0; for k<0, (-k) zeros then 1; then in_expo, then in_frac.
REQ-022 The posit body SHALL be the top 7 bits; guard = 8th bit; sticky = OR of the remaining bits.
REQ-023 in_nar SHALL give 8'h80 and in_zero SHALL give 8'h00, with rounding bypassed; NaR takes priority when both are asserted.
REQ-024 k = +7 SHALL give body 7'h7F (maxpos); k = -7 or -8 SHALL give body 7'h01 (minpos); both cases set out_sat=1.
REQ-025 Rounding SHALL never produce zero or NaR: an incremented body of 0 clamps to 7'h7F.
REQ-026 S3 SHALL output {1'b0,body} if sign=0, else the 8-bit two's complement of {1'b0,body}.
REQ-027 out_sat SHALL travel with its word and be 0 for zero/NaR inputs.

Reset
REQ-028 rst SHALL clear all stage valid bits and set out_valid=0, out_posit=8'h00 and out_sat=0 on the next edge.
REQ-029 rst mid-operation SHALL discard all in-flight words; no word accepted before rst appears after it.
REQ-030 in_ready SHALL be 1 in the cycle after reset.

Configuration
REQ-031 Macro POSIT_ENC_ROUND_EN: defined -> round-to-nearest-even on the body LSB: increment when guard & (sticky | body[0]).
REQ-032 Without POSIT_ENC_ROUND_EN, the body SHALL be truncated; guard and sticky are ignored and S2 passes the body through, latency still 3.

Verification
REQ-033 sign=0, k=0, e=0, f=0000 -> 8'h40 after 3 cycles; same with sign=1 -> 8'hC0.
REQ-034 sign=0, k=2, e=1, f=1011 -> 8'h77 with ROUND_EN, 8'h76 without.
REQ-035 k=+7, sign=0 -> 8'h7F, out_sat=1; k=-8, sign=1 -> 8'hFF, out_sat=1.
REQ-036 in_nar=1 and in_zero=1 together -> 8'h80; in_zero only -> 8'h00; out_sat=0 in both.
REQ-037 Stream 5 words with out_ready held low 4 cycles mid-stream -> in_ready drops, outputs stay stable, all 5 words emerge in order with none lost or duplicated.
REQ-038 Assert rst with 2 words in flight -> out_valid=0 the next cycle, neither word is ever output, and in_ready=1.

Source files
------------

// File: rtl/posit8_1_encoder.sv
// posit<8,1> encoder: 3-stage pipeline turning (sign, regime, exponent, fraction) into a posit word.
// Define POSIT_ENC_ROUND_EN for round-to-nearest-even; otherwise the body is truncated.
module posit8_1_encoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_sign,
  input  logic [3:0] in_regi,
  input  logic       in_expo,
  input  logic [3:0] in_frac,
  input  logic       in_zero,
  input  logic       in_nar,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_posit,
  output logic       out_sat
);

  // All stages advance together; the only stall source is a held output word.
  logic advance;
  assign in_ready = ~out_valid | out_ready;
  assign advance  = in_ready;

  // S1: regime run, terminator, exponent and fraction, left-justified in 12 bits
  logic [3:0]  shamt;
  logic [11:0] run_mask;
  logic [11:0] body12;
  logic        sat_hi, sat_lo;

  always_comb begin
    shamt    = in_regi[3] ? (4'd0 - in_regi) : (in_regi + 4'd1);
    run_mask = ~(12'hFFF >> shamt);
    if (in_regi[3]) begin
      body12 = {1'b1, in_expo, in_frac, 6'b0} >> shamt;
    end else begin
      body12 = ({1'b0, in_expo, in_frac, 6'b0} >> shamt) | run_mask;
    end
    sat_hi = (in_regi == 4'b0111);
    sat_lo = (in_regi == 4'b1001) || (in_regi == 4'b1000);
  end

  logic       s1_valid_q, s1_sign_q, s1_guard_q, s1_sticky_q;
  logic       s1_zero_q, s1_nar_q, s1_sat_hi_q, s1_sat_lo_q;
  logic [6:0] s1_body_q;

  // S2: round (optional) and saturate out-of-range regimes
  logic [6:0] s2_body_d;
  logic       s2_sat_d;

  always_comb begin
    s2_body_d = s1_body_q;
    s2_sat_d  = 1'b0;
`ifdef POSIT_ENC_ROUND_EN
    if (s1_guard_q & (s1_sticky_q | s1_body_q[0])) begin
      s2_body_d = s1_body_q + 7'd1;
      // A wrapped body would read as zero/NaR; pin it at maxpos instead.
      if (s2_body_d == 7'd0) s2_body_d = 7'h7F;
    end
`endif
    if (s1_sat_hi_q) begin
      s2_body_d = 7'h7F;
      s2_sat_d  = 1'b1;
    end else if (s1_sat_lo_q) begin
      s2_body_d = 7'h01;
      s2_sat_d  = 1'b1;
    end
    if (s1_zero_q | s1_nar_q) s2_sat_d = 1'b0;
  end

`ifndef POSIT_ENC_ROUND_EN
  logic unused_round;
  assign unused_round = s1_guard_q ^ s1_sticky_q;
`endif

  logic       s2_valid_q, s2_sign_q, s2_sat_q, s2_zero_q, s2_nar_q;
  logic [6:0] s2_body_q;

  // S3: special values and sign negation
  logic [7:0] out_posit_d;

  always_comb begin
    out_posit_d = {1'b0, s2_body_q};
    if (s2_nar_q) begin
      out_posit_d = 8'h80;
    end else if (s2_zero_q) begin
      out_posit_d = 8'h00;
    end else if (s2_sign_q) begin
      out_posit_d = 8'd0 - {1'b0, s2_body_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_body_q   <= 7'd0;
      s1_guard_q  <= 1'b0;
      s1_sticky_q <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_nar_q    <= 1'b0;
      s1_sat_hi_q <= 1'b0;
      s1_sat_lo_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_body_q   <= 7'd0;
      s2_sat_q    <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_nar_q    <= 1'b0;
      out_valid   <= 1'b0;
      out_posit   <= 8'h00;
      out_sat     <= 1'b0;
    end else if (advance) begin
      s1_valid_q  <= in_valid;
      s1_sign_q   <= in_sign;
      s1_body_q   <= body12[11:5];
      s1_guard_q  <= body12[4];
      s1_sticky_q <= |body12[3:0];
      s1_zero_q   <= in_zero;
      s1_nar_q    <= in_nar;
      s1_sat_hi_q <= sat_hi;
      s1_sat_lo_q <= sat_lo;
      s2_valid_q  <= s1_valid_q;
      s2_sign_q   <= s1_sign_q;
      s2_body_q   <= s2_body_d;
      s2_sat_q    <= s2_sat_d;
      s2_zero_q   <= s1_zero_q;
      s2_nar_q    <= s1_nar_q;
      out_valid   <= s2_valid_q;
      if (s2_valid_q) begin
        out_posit <= out_posit_d;
        out_sat   <= s2_sat_q;
      end
    end
  end

endmodule

// File: tb/tb_posit8_1_encoder.sv
// Scoreboard bench for posit8_1_encoder; expected words come from literals or a bit-string model.
module tb_posit8_1_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_sign, in_expo, in_zero, in_nar;
  logic [3:0] in_regi, in_frac;
  logic       out_valid, out_ready, out_sat;
  logic [7:0] out_posit;

  int n_checks = 0;
  int n_fail   = 0;
  int rx_count = 0;
  logic [8:0] exp_q[$];

  posit8_1_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_regi   (in_regi),
    .in_expo   (in_expo),
    .in_frac   (in_frac),
    .in_zero   (in_zero),
    .in_nar    (in_nar),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_posit (out_posit),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {sat, posit}; builds the regime string bit by bit.
  function automatic logic [8:0] model(input logic s, input logic [3:0] k, input logic e,
                                       input logic [3:0] f, input logic z, input logic n);
    logic [19:0] str;
    logic [6:0]  body;
    logic [7:0]  w;
    logic        sat, guard, sticky;
    int kk, pos;
    if (n) return 9'h080;
    if (z) return 9'h000;
    kk  = int'($signed(k));
    sat = 1'b0;
    if (kk >= 7) begin
      body = 7'h7F;
      sat  = 1'b1;
    end else if (kk <= -7) begin
      body = 7'h01;
      sat  = 1'b1;
    end else begin
      str = '0;
      pos = 0;
      if (kk >= 0) begin
        for (int i = 0; i < kk + 1; i++) begin str[19 - pos] = 1'b1; pos++; end
        str[19 - pos] = 1'b0; pos++;
      end else begin
        for (int i = 0; i < -kk; i++) begin str[19 - pos] = 1'b0; pos++; end
        str[19 - pos] = 1'b1; pos++;
      end
      str[19 - pos] = e; pos++;
      for (int i = 3; i >= 0; i--) begin str[19 - pos] = f[i]; pos++; end
      body   = str[19:13];
      guard  = str[12];
      sticky = |str[11:8];
`ifdef POSIT_ENC_ROUND_EN
      if (guard & (sticky | body[0])) begin
        body = body + 7'd1;
        if (body == 7'd0) body = 7'h7F;
      end
`else
      if (guard & sticky) body = body;
`endif
    end
    w = {1'b0, body};
    if (s) w = 8'd0 - w;
    return {sat, w};
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic s, input logic [3:0] k, input logic e, input logic [3:0] f,
                      input logic z, input logic n, input logic [8:0] exp);
    bit ok = 0;
    in_sign = s; in_regi = k; in_expo = e; in_frac = f; in_zero = z; in_nar = n;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    check("send_accept", 32'(ok), 32'd1);
    if (ok) exp_q.push_back(exp);
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input bit allow_special);
    logic s, e, z, n;
    logic [3:0] k, f;
    s = 1'($urandom_range(0, 1));
    e = 1'($urandom_range(0, 1));
    k = 4'($urandom_range(0, 15));
    f = 4'($urandom_range(0, 15));
    z = allow_special && ($urandom_range(0, 9) == 0);
    n = allow_special && ($urandom_range(0, 9) == 0);
    send(s, k, e, f, z, n, model(s, k, e, f, z, n));
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Output monitor: every valid cycle must show the oldest expected word.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        check("out_word", 32'({out_sat, out_posit}), 32'(exp_q[0]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          rx_count++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat, rx0;
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_regi = 4'd0; in_expo = 1'b0;
    in_frac = 4'd0; in_zero = 1'b0; in_nar = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_posit", 32'(out_posit), 32'h00);
    check("reset_sat", 32'(out_sat), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Unit value, latency of the first word
    send(1'b0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 9'h040);
    lat = 0;
    while (!out_valid && lat < 10) begin @(negedge clk); lat++; end
    check("latency", 32'(lat), 32'd3);
    @(posedge clk); #1;
    send(1'b1, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 9'h0C0);
`ifdef POSIT_ENC_ROUND_EN
    send(1'b0, 4'd2, 1'b1, 4'b1011, 1'b0, 1'b0, 9'h077);
`else
    send(1'b0, 4'd2, 1'b1, 4'b1011, 1'b0, 1'b0, 9'h076);
`endif
    send(1'b0, 4'd7, 1'b0, 4'b0000, 1'b0, 1'b0, 9'h17F);
    send(1'b1, 4'b1000, 1'b1, 4'b1111, 1'b0, 1'b0, 9'h1FF);
    send(1'b0, 4'd7, 1'b1, 4'b0101, 1'b1, 1'b1, 9'h080);
    send(1'b1, 4'b1001, 1'b0, 4'b0110, 1'b1, 1'b0, 9'h000);
    for (int i = 0; i < 40; i++) send_rand(1'b1);
    drain();

    // Back-pressure mid-stream
    @(posedge clk); #1;
    rx0 = rx_count;
    fork
      begin
        for (int i = 0; i < 5; i++) send_rand(1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stream_count", 32'(rx_count - rx0), 32'd5);

    // Reset with two words in flight
    @(posedge clk); #1;
    send_rand(1'b0);
    send_rand(1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_valid_next", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("flush_valid", 32'(out_valid), 32'd0);
    end

    // Pipeline still works after the flush
    @(posedge clk); #1;
    send(1'b0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 9'h040);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
